// File: rtl/usb_pkg.sv
// Shared USB transmit definitions: FSM state encoding, bit-stuff limit and SYNC pattern.
package usb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StSync,
    StSend,
    StStuff,
    StEop,
    StDone
  } state_e;

  localparam int unsigned STUFF_LIMIT  = 6;
  // Sent LSB-first: seven 0s then a 1.
  localparam logic [7:0]  SYNC_PATTERN = 8'b1000_0000;

endpackage

// File: rtl/nrzi_stuff.sv
// USB transmit NRZI encoder with bit stuffing, packet framing and underrun detection.
// Define NRZI_SYNC_GEN_EN to generate the 8-bit SYNC field internally after START.
module nrzi_stuff
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pkt_start,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic pkt_end,
  input  logic sent_pkt,
  output logic bit_ready,
  output logic s_out,
  output logic start_dpdm,
  output logic eop,
  output logic busy,
  output logic underrun
);

  state_e     state_q, state_d;
  logic       lvl_q, lvl_d;
  logic [2:0] ones_q, ones_d;
  logic       end_q, end_d;
  logic       line_bit;
  logic       data;

`ifdef NRZI_SYNC_GEN_EN
  logic [2:0] sync_cnt_q, sync_cnt_d;
`endif

  // Which cycles put a bit on the line, and what data bit it is.
  always_comb begin
    line_bit = 1'b0;
    data     = 1'b1;
    unique case (state_q)
`ifdef NRZI_SYNC_GEN_EN
      StSync: begin
        line_bit = 1'b1;
        data     = SYNC_PATTERN[sync_cnt_q];
      end
`endif
      StSend: begin
        line_bit = bit_valid;
        data     = bit_in;
      end
      StStuff: begin
        line_bit = 1'b1;
        data     = 1'b0;
      end
      default: ;
    endcase
  end

  assign s_out = (line_bit && !data) ? ~lvl_q : lvl_q;

  always_comb begin
    lvl_d  = lvl_q;
    ones_d = ones_q;
    if (line_bit) begin
      lvl_d  = s_out;
      ones_d = data ? ones_q + 3'd1 : 3'd0;
    end
    if (state_q == StStart || state_q == StEop) begin
      ones_d = 3'd0;
    end
    if (state_q == StEop) begin
      lvl_d = 1'b1;
    end
  end

`ifdef NRZI_SYNC_GEN_EN
  assign sync_cnt_d = (state_q == StSync) ? sync_cnt_q + 3'd1 : 3'd0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    end_d   = end_q;
    unique case (state_q)
      StIdle: begin
        if (pkt_start) begin
          state_d = StStart;
        end
      end
      StStart: begin
        end_d = 1'b0;
`ifdef NRZI_SYNC_GEN_EN
        state_d = StSync;
`else
        state_d = StSend;
`endif
      end
      StSync: begin
`ifdef NRZI_SYNC_GEN_EN
        if (sync_cnt_q == 3'd7) begin
          state_d = StSend;
        end
`else
        state_d = StIdle;
`endif
      end
      StSend: begin
        if (!bit_valid) begin
          state_d = StEop;
        end else if (ones_d == 3'(STUFF_LIMIT)) begin
          // Remember a last bit that needs a stuff bit before EOP.
          state_d = StStuff;
          end_d   = pkt_end;
        end else if (pkt_end) begin
          state_d = StEop;
        end
      end
      StStuff: begin
        state_d = end_q ? StEop : StSend;
        end_d   = 1'b0;
      end
      StEop: begin
        state_d = StDone;
      end
      StDone: begin
        if (sent_pkt) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lvl_q   <= 1'b1;
      ones_q  <= 3'd0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      ones_q  <= ones_d;
      end_q   <= end_d;
    end
  end

`ifdef NRZI_SYNC_GEN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_cnt_q <= 3'd0;
    end else begin
      sync_cnt_q <= sync_cnt_d;
    end
  end
`endif

  // Outputs
  always_comb begin
    bit_ready  = (state_q == StSend);
    start_dpdm = (state_q == StStart);
    eop        = (state_q == StEop);
    busy       = (state_q != StIdle);
    underrun   = (state_q == StSend) && !bit_valid;
  end

endmodule

// File: tb/tb_nrzi_stuff.sv
// Scoreboard bench for nrzi_stuff: random packets checked against a bitstream-level model.
module tb_nrzi_stuff;

  logic clk = 1'b0;
  logic rst, pkt_start, bit_in, bit_valid, pkt_end, sent_pkt;
  logic bit_ready, s_out, start_dpdm, eop, busy, underrun;

  nrzi_stuff dut (
    .clk       (clk),
    .rst       (rst),
    .pkt_start (pkt_start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .pkt_end   (pkt_end),
    .sent_pkt  (sent_pkt),
    .bit_ready (bit_ready),
    .s_out     (s_out),
    .start_dpdm(start_dpdm),
    .eop       (eop),
    .busy      (busy),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_sent = 0;
  int n_checked = 0;
  bit mon_en = 1'b1;

  bit pl[$];
  bit exp_bits[$];
  int exp_len[$];
  int exp_rdy[$];
  int exp_ur[$];

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Expected line levels: SYNC prefix, stuff a 0 after every six 1s, NRZI (0 toggles).
  task automatic model(input bit has_gap, input int gap_at);
    bit d[$];
    bit lv = 1'b1;
    int run = 0;
    int cnt = 0;
    int used;
`ifdef NRZI_SYNC_GEN_EN
    for (int i = 0; i < 7; i++) d.push_back(1'b0);
    d.push_back(1'b1);
`endif
    used = has_gap ? gap_at : pl.size();
    for (int i = 0; i < used; i++) d.push_back(pl[i]);
    foreach (d[i]) begin
      if (!d[i]) lv = ~lv;
      exp_bits.push_back(lv);
      cnt++;
      run = d[i] ? run + 1 : 0;
      if (run == 6) begin
        lv = ~lv;
        exp_bits.push_back(lv);
        cnt++;
        run = 0;
      end
    end
    if (has_gap) begin
      exp_bits.push_back(lv);
      cnt++;
    end
    exp_len.push_back(cnt);
    exp_rdy.push_back(has_gap ? used + 1 : used);
    exp_ur.push_back(has_gap ? 1 : 0);
  endtask

  // Monitor: collects line levels between start_dpdm and eop, then scores the packet.
  initial begin
    bit obs[$];
    bit in_pkt = 1'b0;
    int rdy_cnt = 0;
    int ur_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_pkt = 1'b0;
      end else if (mon_en) begin
        if (in_pkt) begin
          if (eop) begin
            in_pkt = 1'b0;
            if (exp_len.size() == 0) begin
              chk("unexpected_packet", 1, 0);
            end else begin
              int len;
              int bad = 0;
              len = exp_len.pop_front();
              chk("line_len", obs.size(), len);
              for (int i = 0; i < len; i++) begin
                bit eb;
                eb = exp_bits.pop_front();
                if (i >= obs.size() || obs[i] != eb) bad++;
              end
              chk("line_levels", bad, 0);
              chk("ready_cycles", rdy_cnt, exp_rdy.pop_front());
              chk("underrun_pulses", ur_cnt, exp_ur.pop_front());
              n_checked++;
            end
          end else begin
            obs.push_back(s_out);
            rdy_cnt += int'(bit_ready);
            ur_cnt += int'(underrun);
          end
        end else begin
          if (eop) chk("stray_eop", 1, 0);
          if (start_dpdm) begin
            in_pkt = 1'b1;
            obs.delete();
            rdy_cnt = 0;
            ur_cnt = 0;
          end
        end
      end
    end
  end

  task automatic run_pkt(input bit has_gap, input int gap_at);
    int  n = pl.size();
    int  idx = 0;
    bit  under_taken = 1'b0;
    bit  took, ut;
    model(has_gap, gap_at);
    n_sent++;
    pkt_start = 1'b1;
    @(posedge clk); #1;
    pkt_start = 1'b0;
    chk("start_dpdm", start_dpdm, 1);
    chk("busy_start", busy, 1);
    for (int c = 0; c < 400 && idx < n && !under_taken; c++) begin
      bit_in    = pl[idx];
      pkt_end   = !has_gap && (idx == n - 1);
      bit_valid = !(has_gap && idx == gap_at && bit_ready);
      #1;
      took = bit_ready && bit_valid;
      ut   = bit_ready && !bit_valid;
      if (ut) chk("underrun_now", underrun, 1);
      @(posedge clk); #1;
      if (took) idx++;
      if (ut) under_taken = 1'b1;
    end
    bit_valid = 1'b0;
    pkt_end   = 1'b0;
    if (has_gap) chk("eop_after_underrun", eop, 1);
    for (int k = 0; k < 40; k++) begin
      if (eop) break;
      @(posedge clk); #1;
    end
    chk("eop_seen", eop, 1);
    @(posedge clk); #1;
    chk("eop_one_cycle", eop, 0);
    chk("busy_done", busy, 1);
    pkt_start = 1'b1;
    @(posedge clk); #1;
    pkt_start = 1'b0;
    chk("done_ignores_start", start_dpdm, 0);
    chk("busy_held", busy, 1);
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
    end
    sent_pkt = 1'b1;
    @(posedge clk); #1;
    sent_pkt = 1'b0;
    chk("idle_after_sent", busy, 0);
  endtask

  task automatic reset_mid_send();
    mon_en = 1'b0;
    pkt_start = 1'b1;
    @(posedge clk); #1;
    pkt_start = 1'b0;
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    for (int c = 0; c < 40 && !bit_ready; c++) begin
      @(posedge clk); #1;
    end
    chk("reached_send", bit_ready, 1);
    repeat (2) begin
      bit_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #2;
    chk("rst_sout", s_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_eop", eop, 0);
    chk("rst_ready", bit_ready, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_start", start_dpdm, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bit_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_no_eop", eop, 0);
      chk("post_rst_sout", s_out, 1);
    end
    mon_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pkt_start = 1'b0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    pkt_end = 1'b0;
    sent_pkt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sout", s_out, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ready", bit_ready, 0);
    chk("reset_eop", eop, 0);
    chk("reset_start", start_dpdm, 0);
    chk("reset_underrun", underrun, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    pl.delete();
    for (int i = 0; i < 8; i++) pl.push_back(1'b0);
    run_pkt(1'b0, 0);

    pl.delete();
    for (int i = 0; i < 7; i++) pl.push_back(1'b1);
    run_pkt(1'b0, 0);

    pl.delete();
    for (int i = 0; i < 6; i++) pl.push_back(1'b1);
    run_pkt(1'b0, 0);

    pl.delete();
    pl.push_back(1'b1); pl.push_back(1'b0); pl.push_back(1'b1);
    pl.push_back(1'b1); pl.push_back(1'b1);
    run_pkt(1'b1, 3);

    reset_mid_send();

    for (int p = 0; p < 40; p++) begin
      int n;
      bit g;
      n = $urandom_range(1, 24);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back($urandom_range(0, 3) != 0);
      g = ($urandom_range(0, 3) == 0);
      run_pkt(g, $urandom_range(0, n - 1));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("packets_scored", n_checked, n_sent);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
